// File: rtl/fp_pkg.sv
// Shared floating-point definitions for fp_multiplier and fp_division:
// IEEE-754 single field widths, canonical constants and the multiplier FSM states.
package fp_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } fp_mul_state_t;

endpackage

// File: rtl/fp_mul_special.sv
// Combinational special-operand classifier for fp_multiplier, used only when
// FP_MUL_SPECIAL_EN is defined. Exponent-0 operands count as zero (denormals flush).
module fp_mul_special
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        override,
  output logic [31:0] result
);

  logic sign;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sign   = a[31] ^ b[31];
  assign a_zero = (a[30:23] == '0);
  assign b_zero = (b[30:23] == '0);
  assign a_inf  = (&a[30:23]) && (a[FP_MAN_W-1:0] == '0);
  assign b_inf  = (&b[30:23]) && (b[FP_MAN_W-1:0] == '0);
  assign a_nan  = (&a[30:23]) && (a[FP_MAN_W-1:0] != '0);
  assign b_nan  = (&b[30:23]) && (b[FP_MAN_W-1:0] != '0);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    override = 1'b0;
    result   = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      override = 1'b1;
      result   = FP_QNAN;
    end else if (a_inf || b_inf) begin
      override = 1'b1;
      result   = FP_POS_INF | {sign, 31'b0};
    end else if (a_zero || b_zero) begin
      override = 1'b1;
      result   = {sign, 31'b0};
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// Sequential IEEE-754 single multiplier: 24-cycle shift-add mantissa loop, truncating
// normalization, valid/ready on both sides. Define FP_MUL_SPECIAL_EN for zero/inf/NaN handling.
module fp_multiplier
  import fp_pkg::*;
#(
  parameter int MUL_BITS = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c
);

  localparam int ACC_W = 2 * MUL_BITS;
  localparam int CNT_W = $clog2(MUL_BITS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_BITS - 1);

  fp_mul_state_t       state;
  logic [31:0]         a_r, b_r;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;

  logic [MUL_BITS-1:0] ma, mb;
  logic                sign;
  logic signed [9:0]   e_sum, e_norm;
  logic [FP_MAN_W-1:0] mant;
  logic [31:0]         norm_c;
  logic                unused_bits;

  // Hidden bit is always forced; denormal handling lives in the special path only.
  assign ma   = {1'b1, a_r[FP_MAN_W-1:0]};
  assign mb   = {1'b1, b_r[FP_MAN_W-1:0]};
  assign sign = a_r[31] ^ b_r[31];

  // Biased exponents summed in 10 bits so overflow/underflow stay visible as a signed value.
  assign e_sum = 10'(a_r[30:23]) + 10'(b_r[30:23]) - 10'(FP_EXP_BIAS);

  always_comb begin
    if (acc[ACC_W-1]) begin
      mant   = acc[ACC_W-2 -: FP_MAN_W];
      e_norm = e_sum + 10'sd1;
    end else begin
      mant   = acc[ACC_W-3 -: FP_MAN_W];
      e_norm = e_sum;
    end
  end

  assign unused_bits = ^{acc[ACC_W-FP_MAN_W-3:0], e_norm[9:8]};

`ifdef FP_MUL_SPECIAL_EN
  logic        spec_override;
  logic [31:0] spec_result;

  fp_mul_special u_special (
    .a        (a_r),
    .b        (b_r),
    .override (spec_override),
    .result   (spec_result)
  );

  always_comb begin
    if (spec_override)
      norm_c = spec_result;
    else if (e_norm >= 10'sd255)
      norm_c = FP_POS_INF | {sign, 31'b0};
    else if (e_norm <= 10'sd0)
      norm_c = {sign, 31'b0};
    else
      norm_c = {sign, e_norm[FP_EXP_W-1:0], mant};
  end
`else
  assign norm_c = {sign, e_norm[FP_EXP_W-1:0], mant};
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a1;
            b_r      <= b1;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mb[cnt])
            acc <= acc + (ACC_W'(ma) << cnt);
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER)
            state <= ST_NORM;
        end
        ST_NORM: begin
          c         <= norm_c;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Self-checking bench for fp_multiplier: directed vectors, handshake/latency timing,
// mid-operation reset and randomized operands against a behavioural reference model.
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a1 = '0;
  logic [31:0] b1 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] c;

  int checks = 0;
  int errors = 0;

  fp_multiplier #(.MUL_BITS(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .b1        (b1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then normalize and truncate.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int              e;
    logic [22:0]     m;
    logic            s;
    s = a[31] ^ b[31];
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
`ifdef FP_MUL_SPECIAL_EN
    begin
      bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      a_zero = (a[30:23] == 8'd0);
      b_zero = (b[30:23] == 8'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {s, 31'd0};
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0) return {s, 31'd0};
    end
`endif
    return {s, e[7:0], m};
  endfunction

  // Waits for in_ready, presents operands for one accept edge, returns at the following negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a1 = a;
    b1 = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a1 = $urandom;
    b1 = $urandom;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Counts cycles from the accept cycle (=1) until out_valid; optionally pokes in_valid mid-op.
  task automatic wait_result(input string tag, input logic [31:0] exp, input bit poke);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      if (poke && lat == 5) begin
        in_valid = 1'b1;
        a1 = $urandom;
        b1 = $urandom;
      end
      if (poke && lat == 15) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check(tag, c, exp);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(a, b);
    wait_result(tag, exp, 1'b1);
    drain();
  endtask

  initial begin
    logic [31:0] ra, rb, held_c;

    #12;
    check("reset_c", c, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    run_op("mul_1p5x1p5", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);

    // Backpressure: result and flags hold while the consumer stalls.
    issue(32'hC000_0000, 32'h3F00_0000);
    wait_result("mul_m2x0p5", 32'hBF80_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_c", c, 32'hBF80_0000);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    drain();

`ifdef FP_MUL_SPECIAL_EN
    run_op("spec_overflow", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    run_op("spec_zero", 32'h0000_0000, 32'h4040_0000, 32'h0000_0000);
    run_op("spec_inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
`endif

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand", ra, rb, ref_mul(ra, rb));
    end

    // Make sure c holds a non-zero value so the reset clear is observable.
    run_op("pre_reset", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    issue(32'h3FC0_0000, 32'h4040_0000);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_c", c, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000);

    // Back-to-back with out_ready held: exactly one idle cycle between result and next accept.
    ra = $urandom;
    rb = $urandom;
    issue(32'h3FC0_0000, 32'h3FC0_0000);
    a1 = ra;
    b1 = rb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    wait_result("b2b_first", 32'h4010_0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_gap_out_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_gap_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("b2b_second", ref_mul(ra, rb), 1'b0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_done_out_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
